// File: rtl/hex_to_ps2_tx.sv
// hex_to_ps2_tx: sends the PS/2 set-2 make code for a 4-bit hex value as a
// device-driven PS/2 stream. The bit clock and data are generated locally.
//
// Build option: define HEX_TO_PS2_TX_BREAK_CODE_EN to send make, F0, make
// with an idle gap between frames. When it is left undefined, only the make
// byte is sent.
//
// Handshake: start is a single-cycle request. It is honoured only when the
// FSM is in IDLE. An accepted start raises busy on the next cycle, and busy
// stays high through FIN, where done pulses for one cycle. A start with
// hex > 8'h0F is refused: err pulses on the next cycle and busy stays low.
// A start that arrives while busy is high is dropped.
`timescale 1ns/1ps

module hex_to_ps2_tx #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hex,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DW      = $clog2(MAX_CNT + 1);

  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd10;
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIT_HI = 3'd1,
    BIT_LO = 3'd2,
    GAP    = 3'd3,
    FIN    = 3'd4
  } state_t;

  // Kept as a named enum so that checkers can bind to the FSM state.
  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      cur_byte;
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
  logic [7:0]      make_code;
  logic [1:0]      frame_idx;
`endif

  // Set-2 make code for each hex digit.
  function automatic logic [7:0] make_of(input logic [3:0] h);
    logic [7:0] c;
    case (h)
      4'h0: c = 8'h45;
      4'h1: c = 8'h16;
      4'h2: c = 8'h1E;
      4'h3: c = 8'h26;
      4'h4: c = 8'h25;
      4'h5: c = 8'h2E;
      4'h6: c = 8'h36;
      4'h7: c = 8'h3D;
      4'h8: c = 8'h3E;
      4'h9: c = 8'h46;
      4'hA: c = 8'h1C;
      4'hB: c = 8'h32;
      4'hC: c = 8'h21;
      4'hD: c = 8'h23;
      4'hE: c = 8'h24;
      default: c = 8'h2B;
    endcase
    return c;
  endfunction

  // Frame bit idx of an 11-bit frame. Bit 0 is the start bit, bits 1-8 are
  // the data LSB first, bit 9 is odd parity and bit 10 is the stop bit.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic r;
    if (idx == 4'd0)       r = 1'b0;
    else if (idx <= 4'd8)  r = b[3'(idx - 4'd1)];
    else if (idx == 4'd9)  r = ~^b;
    else                   r = 1'b1;
    return r;
  endfunction

  // Single FSM that registers every output. ps2_data is updated only on
  // entry to BIT_HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cur_byte  <= '0;
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
      make_code <= '0;
      frame_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (hex[7:4] != 4'h0) begin
              err <= 1'b1;
            end else begin
              cur_byte  <= make_of(hex[3:0]);
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
              make_code <= make_of(hex[3:0]);
              frame_idx <= 2'd0;
`endif
              state     <= BIT_HI;
              busy      <= 1'b1;
              ps2_clk   <= 1'b1;
              ps2_data  <= 1'b0;
              div_cnt   <= '0;
              bit_cnt   <= '0;
            end
          end
        end

        BIT_HI: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            ps2_clk <= 1'b0;
            state   <= BIT_LO;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        BIT_LO: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            ps2_clk <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              ps2_data <= 1'b1;
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
              if (frame_idx == 2'd2) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state     <= GAP;
                frame_idx <= frame_idx + 2'd1;
              end
`else
              state <= FIN;
              done  <= 1'b1;
`endif
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              ps2_data <= frame_bit(cur_byte, bit_cnt + 4'd1);
              state    <= BIT_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        GAP: begin
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
          if (div_cnt == GAP_LAST) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            ps2_data <= 1'b0;
            cur_byte <= (frame_idx == 2'd1) ? 8'hF0 : make_code;
            state    <= BIT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_to_ps2_tx.sv
// tb_hex_to_ps2_tx: self-checking bench for hex_to_ps2_tx.
// CLK_DIV=4, GAP_CYCLES=10. Frames are decoded from ps2_clk/ps2_data and
// compared against expected bytes and sequence lengths queued by the driver.
`timescale 1ns/1ps

module tb_hex_to_ps2_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 10;
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
  localparam int SEQ_LEN = 66*CLK_DIV + 2*GAP_CYCLES + 1;
`else
  localparam int SEQ_LEN = 22*CLK_DIV + 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] hex;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] len_q[$];

  logic [7:0] mk_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  hex_to_ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .hex      (hex),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // monitor / scoreboard (samples on the falling edge)
  logic        in_seq   = 1'b0;
  logic        run_ok   = 1'b0;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          bit_n    = 0;
  int          hi_cnt   = 0;
  int          lo_cnt   = 0;
  logic [10:0] fr;
  logic [7:0]  want_b;
  logic [31:0] want_l;

  initial begin
    fr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_seq = 1'b0; run_ok = 1'b0; busy_cnt = 0; done_cnt = 0;
        bit_n = 0; hi_cnt = 0; lo_cnt = 0;
      end else begin
        if (done || err) chk("done_err_excl", {31'd0, done & err}, 32'd0);
        if (done && !in_seq) chk("stray_done", 32'd1, 32'd0);
        if (ps2_data != prev_dat) chk("data_edge_clk_high", {31'd0, ps2_clk}, 32'd1);
        if (busy) begin
          in_seq = 1'b1;
          busy_cnt++;
          if (done) done_cnt++;
        end
        // falling ps2_clk: sample one frame bit
        if (prev_clk && !ps2_clk && in_seq) begin
          if (bit_n > 0) chk("hi_len", hi_cnt, CLK_DIV);
          run_ok = 1'b1;
          fr[bit_n] = ps2_data;
          bit_n++;
          if (bit_n == 11) begin
            chk("start_bit", {31'd0, fr[0]}, 32'd0);
            chk("stop_bit", {31'd0, fr[10]}, 32'd1);
            chk("odd_parity", {31'd0, ^fr[9:1]}, 32'd1);
            if (exp_q.size() == 0) chk("unexpected_frame", {24'd0, fr[8:1]}, 32'hFFFF);
            else begin
              want_b = exp_q.pop_front();
              chk("frame_byte", {24'd0, fr[8:1]}, {24'd0, want_b});
            end
            bit_n = 0;
          end
        end
        if (!prev_clk && ps2_clk && run_ok) chk("lo_len", lo_cnt, CLK_DIV);
        if (ps2_clk && !prev_clk) hi_cnt = 0;
        if (!ps2_clk && prev_clk) lo_cnt = 0;
        if (ps2_clk) hi_cnt++; else lo_cnt++;
        // end of sequence
        if (in_seq && !busy) begin
          if (len_q.size() == 0) chk("unexpected_seq", busy_cnt, 32'hFFFF);
          else begin
            want_l = len_q.pop_front();
            chk("busy_len", busy_cnt, want_l);
          end
          chk("done_count", done_cnt, 1);
          chk("frame_tail", bit_n, 0);
          in_seq = 1'b0; busy_cnt = 0; done_cnt = 0; run_ok = 1'b0;
        end
      end
      prev_clk = ps2_clk;
      prev_dat = ps2_data;
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [7:0] h);
    wait_idle();
    @(posedge clk); #1;
    hex = h; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (h <= 8'h0F) begin
      exp_q.push_back(mk_tab[h[3:0]]);
`ifdef HEX_TO_PS2_TX_BREAK_CODE_EN
      exp_q.push_back(8'hF0);
      exp_q.push_back(mk_tab[h[3:0]]);
`endif
      len_q.push_back(SEQ_LEN);
      chk("accept_busy", {31'd0, busy}, 32'd1);
      chk("accept_no_err", {31'd0, err}, 32'd0);
    end else begin
      chk("illegal_err", {31'd0, err}, 32'd1);
      chk("illegal_busy", {31'd0, busy}, 32'd0);
      chk("illegal_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
      @(posedge clk); #1;
      chk("illegal_err_1cyc", {31'd0, err}, 32'd0);
      chk("illegal_busy_late", {31'd0, busy}, 32'd0);
    end
  endtask

  // stimulus
  logic [7:0] rh;

  initial begin
    reset = 1'b1; start = 1'b0; hex = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    reset = 1'b0;

    // legal send of 5 -> 2E
    send(8'h05);
    wait_idle();

    // illegal value
    send(8'h1A);

    // start while busy is ignored
    send(8'h03);
    repeat (20) @(posedge clk);
    #1 hex = 8'h0F; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // reset during bit 5 of the first frame
    send(8'h07);
    repeat (42) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    len_q.delete();
    repeat (30) @(posedge clk);
    #1 chk("no_resume", {31'd0, busy}, 32'd0);

    // reset and start together: reset wins
    @(posedge clk); #1 reset = 1'b1; start = 1'b1; hex = 8'h02;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    chk("rst_vs_start_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1 chk("rst_vs_start_idle", {30'd0, ps2_clk, ps2_data}, 32'd3);

    // full sweep, back-to-back
    for (int i = 0; i < 16; i++) send(8'(i));

    // a few random values, legal and illegal
    repeat (6) begin
      rh = 8'($urandom_range(0, 31));
      send(rh);
    end

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("len_q_drained", len_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
